// File: rtl/cmp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cmp_pkg
// Purpose  : Shared state encoding and width helpers for cmp_search_ctrl.
// Revision : 1.0
// ============================================================================
package cmp_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PROBE  = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    // Counter must hold WIDTH+1 probes, the longest consistent search.
    function automatic int iter_cnt_width(input int width);
        return $clog2(width + 2);
    endfunction

endpackage
`default_nettype wire

// File: rtl/cmp_flag_check.sv
`default_nettype none
// ============================================================================
// Module   : cmp_flag_check
// Purpose  : Validates comparator flags (exactly one high) and decodes them.
// Revision : 1.0
// ============================================================================
module cmp_flag_check (
    input  logic a_gra_b,
    input  logic a_less_b,
    input  logic a_equ_b,
    output logic legal,
    output logic gt,
    output logic lt,
    output logic eq
);

    // Three-way XOR is high for one or three set flags; exclude the latter.
    assign legal = (a_gra_b ^ a_less_b ^ a_equ_b) & ~(a_gra_b & a_less_b & a_equ_b);
    assign gt    = legal & a_gra_b;
    assign lt    = legal & a_less_b;
    assign eq    = legal & a_equ_b;

endmodule
`default_nettype wire

// File: rtl/cmp_search_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : cmp_search_ctrl
// Purpose  : Binary-search controller driving the probe side of a magnitude
//            comparator. Optional iteration counter: CMP_SEARCH_ITER_CNT_EN.
// Revision : 1.0
// ============================================================================
module cmp_search_ctrl
    import cmp_pkg::*;
#(
    parameter int WIDTH = 4
`ifdef CMP_SEARCH_ITER_CNT_EN
    ,
    localparam int ITER_W = iter_cnt_width(WIDTH)
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             a_gra_b,
    input  logic             a_less_b,
    input  logic             a_equ_b,
    output logic [WIDTH-1:0] probe,
    output logic             busy,
    output logic             done,
    output logic             found,
    output logic             err,
    output logic [WIDTH-1:0] result
`ifdef CMP_SEARCH_ITER_CNT_EN
    ,
    output logic [ITER_W-1:0] iters
`endif
);

    // Bounds carry one extra bit so probe+1 at the top of the range cannot wrap.
    localparam int              BW    = WIDTH + 1;
    localparam logic [BW-1:0]   C_MAX = {1'b0, {WIDTH{1'b1}}};

    state_t           r_state, w_state_nxt;
    logic [BW-1:0]    r_lo, w_lo_nxt;
    logic [BW-1:0]    r_hi, w_hi_nxt;
    logic [WIDTH-1:0] r_probe, w_probe_nxt;
    logic [WIDTH-1:0] r_result, w_result_nxt;
    logic             r_found, w_found_nxt;
    logic             r_err, w_err_nxt;

    logic [BW-1:0]    w_sum;
    logic [BW-1:0]    w_probe_ext;
    logic [BW-1:0]    w_probe_inc;
    logic [BW-1:0]    w_probe_dec;
    logic             w_legal, w_gt, w_lt, w_eq;

`ifdef CMP_SEARCH_ITER_CNT_EN
    logic [ITER_W-1:0] r_iter, w_iter_nxt;
`endif

    cmp_flag_check u_flag_check (
        .a_gra_b  (a_gra_b),
        .a_less_b (a_less_b),
        .a_equ_b  (a_equ_b),
        .legal    (w_legal),
        .gt       (w_gt),
        .lt       (w_lt),
        .eq       (w_eq)
    );

    assign w_sum       = r_lo + r_hi;
    assign w_probe_ext = {1'b0, r_probe};
    assign w_probe_inc = w_probe_ext + BW'(1);
    assign w_probe_dec = w_probe_ext - BW'(1);

    always_comb begin
        w_state_nxt  = r_state;
        w_lo_nxt     = r_lo;
        w_hi_nxt     = r_hi;
        w_probe_nxt  = r_probe;
        w_result_nxt = r_result;
        w_found_nxt  = r_found;
        w_err_nxt    = r_err;
`ifdef CMP_SEARCH_ITER_CNT_EN
        w_iter_nxt   = r_iter;
`endif
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_lo_nxt    = '0;
                    w_hi_nxt    = C_MAX;
                    w_found_nxt = 1'b0;
                    w_err_nxt   = 1'b0;
                    w_state_nxt = PROBE;
`ifdef CMP_SEARCH_ITER_CNT_EN
                    w_iter_nxt  = '0;
`endif
                end
            end
            PROBE: begin
                w_probe_nxt = w_sum[WIDTH:1];
                w_state_nxt = SAMPLE;
            end
            SAMPLE: begin
`ifdef CMP_SEARCH_ITER_CNT_EN
                w_iter_nxt = r_iter + ITER_W'(1);
`endif
                if (!w_legal) begin
                    w_err_nxt   = 1'b1;
                    w_found_nxt = 1'b0;
                    w_state_nxt = DONE;
                end else if (w_eq) begin
                    w_result_nxt = r_probe;
                    w_found_nxt  = 1'b1;
                    w_state_nxt  = DONE;
                end else if (w_gt) begin
                    w_lo_nxt    = w_probe_inc;
                    w_found_nxt = 1'b0;
                    w_state_nxt = (w_probe_inc > r_hi) ? DONE : PROBE;
                end else if (w_lt) begin
                    w_found_nxt = 1'b0;
                    if (w_probe_ext == r_lo) begin
                        w_state_nxt = DONE;
                    end else begin
                        w_hi_nxt    = w_probe_dec;
                        w_state_nxt = PROBE;
                    end
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_lo     <= '0;
            r_hi     <= '0;
            r_probe  <= '0;
            r_result <= '0;
            r_found  <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_lo     <= w_lo_nxt;
            r_hi     <= w_hi_nxt;
            r_probe  <= w_probe_nxt;
            r_result <= w_result_nxt;
            r_found  <= w_found_nxt;
            r_err    <= w_err_nxt;
        end
    end

`ifdef CMP_SEARCH_ITER_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            r_iter <= '0;
        end else begin
            r_iter <= w_iter_nxt;
        end
    end

    assign iters = r_iter;
`endif

    assign probe  = r_probe;
    assign result = r_result;
    assign found  = r_found;
    assign err    = r_err;
    assign busy   = (r_state == PROBE) || (r_state == SAMPLE);
    assign done   = (r_state == DONE);

endmodule
`default_nettype wire

// File: tb/tb_cmp_search_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_cmp_search_ctrl
// Purpose  : Self-checking bench for cmp_search_ctrl paired with a 4-bit
//            behavioural comparator (target on a, probe on b).
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_cmp_search_ctrl;

    localparam int WIDTH = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             a_gra_b, a_less_b, a_equ_b;
    logic [WIDTH-1:0] probe, result;
    logic             busy, done, found, err;
`ifdef CMP_SEARCH_ITER_CNT_EN
    logic [2:0]       iters;
`endif

    logic [WIDTH-1:0] target;
    logic             ovr_en;
    logic [2:0]       ovr_flags;

    int n_cmp = 0;
    int n_bad = 0;
    int exp_probes[$];

    always #5 clk = ~clk;

    // Comparator with an override path for injecting illegal flag patterns.
    assign a_gra_b  = ovr_en ? ovr_flags[2] : (target > probe);
    assign a_less_b = ovr_en ? ovr_flags[1] : (target < probe);
    assign a_equ_b  = ovr_en ? ovr_flags[0] : (target == probe);

    cmp_search_ctrl #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .a_gra_b  (a_gra_b),
        .a_less_b (a_less_b),
        .a_equ_b  (a_equ_b),
        .probe    (probe),
        .busy     (busy),
        .done     (done),
        .found    (found),
        .err      (err),
        .result   (result)
`ifdef CMP_SEARCH_ITER_CNT_EN
        ,
        .iters    (iters)
`endif
    );

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Textbook binary search over [0, 2^WIDTH-1]; records every midpoint tried.
    task automatic model(input int tgt);
        int lo, hi, mid;
        exp_probes.delete();
        lo = 0;
        hi = (1 << WIDTH) - 1;
        while (lo <= hi) begin
            mid = (lo + hi) / 2;
            exp_probes.push_back(mid);
            if (mid == tgt) break;
            else if (tgt > mid) lo = mid + 1;
            else hi = mid - 1;
        end
    endtask

    task automatic run_search(input int tgt, input bit bad, input logic [2:0] badf,
                              input int extra_start_cyc, input bit start_in_done,
                              input string tag);
        int n, cyc, prev_result, exp_result;
        bit got_done, exp_found, exp_err;
        prev_result = int'(result);
        target      = tgt[WIDTH-1:0];
        ovr_en      = bad;
        ovr_flags   = badf;
        model(tgt);
        if (bad) begin
            n = 1; exp_found = 1'b0; exp_err = 1'b1; exp_result = prev_result;
        end else begin
            n = exp_probes.size(); exp_found = 1'b1; exp_err = 1'b0; exp_result = tgt;
        end

        start = 1'b1;
        tick();
        start = 1'b0;
        cyc   = 1;
        check({tag, "_busy_acc"},  int'(busy),  1);
        check({tag, "_found_clr"}, int'(found), 0);
        check({tag, "_err_clr"},   int'(err),   0);

        got_done = 1'b0;
        while (cyc <= 40) begin
            if (done) begin
                got_done = 1'b1;
                break;
            end
            if (cyc % 2 == 0 && cyc / 2 <= n)
                check({tag, "_probe"}, int'(probe), exp_probes[cyc/2 - 1]);
            start = (cyc == extra_start_cyc);
            tick();
            start = 1'b0;
            cyc++;
        end

        check({tag, "_done_seen"}, int'(got_done), 1);
        check({tag, "_latency"},   cyc, 2 * n + 1);
        check({tag, "_found"},     int'(found), int'(exp_found));
        check({tag, "_err"},       int'(err),   int'(exp_err));
        check({tag, "_result"},    int'(result), exp_result);
        check({tag, "_busy_done"}, int'(busy),  0);
`ifdef CMP_SEARCH_ITER_CNT_EN
        check({tag, "_iters"},     int'(iters), n);
`endif

        start = start_in_done;
        tick();
        start  = 1'b0;
        ovr_en = 1'b0;
        check({tag, "_done_pulse"}, int'(done),  0);
        check({tag, "_busy_after"}, int'(busy),  0);
        check({tag, "_found_hold"}, int'(found), int'(exp_found));
        check({tag, "_err_hold"},   int'(err),   int'(exp_err));
    endtask

    initial begin
        logic [2:0] illegal_pats [5];
        int done_cnt;
        illegal_pats = '{3'b000, 3'b011, 3'b101, 3'b110, 3'b111};

        rst = 1'b1; start = 1'b0; target = '0; ovr_en = 1'b0; ovr_flags = '0;
        repeat (3) tick();
        check("rst_probe",  int'(probe),  0);
        check("rst_busy",   int'(busy),   0);
        check("rst_done",   int'(done),   0);
        check("rst_found",  int'(found),  0);
        check("rst_err",    int'(err),    0);
        check("rst_result", int'(result), 0);
`ifdef CMP_SEARCH_ITER_CNT_EN
        check("rst_iters",  int'(iters),  0);
`endif
        rst = 1'b0;
        tick();

        run_search(7,  1'b0, 3'b000, 0, 1'b0, "t7");
        run_search(0,  1'b0, 3'b000, 0, 1'b0, "t0");
        run_search(15, 1'b0, 3'b000, 0, 1'b0, "t15");
        run_search(5,  1'b1, 3'b000, 0, 1'b0, "noflag");
        run_search(10, 1'b0, 3'b000, 3, 1'b0, "restart");
        run_search(3,  1'b1, 3'b111, 0, 1'b0, "allflag");
        run_search(12, 1'b0, 3'b000, 0, 1'b1, "start_in_done");

        // Reset in the middle of a search aborts without a done pulse.
        target = 4'd10;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_busy",   int'(busy),   0);
        check("abort_done",   int'(done),   0);
        check("abort_probe",  int'(probe),  0);
        check("abort_result", int'(result), 0);
        done_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            if (done) done_cnt++;
            tick();
        end
        check("abort_no_done", done_cnt, 0);

        for (int k = 0; k < 24; k++) begin
            int  tgt;
            bit  bad;
            tgt = int'($urandom_range(0, 15));
            bad = ($urandom_range(0, 5) == 0);
            run_search(tgt, bad, illegal_pats[$urandom_range(0, 4)],
                       int'($urandom_range(0, 8)), bit'($urandom_range(0, 1)), "rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
